// File: rtl/frog_position_ctrl.sv
// Frog position controller: debounces four buttons, queues one grid step per press,
// and commits the step only at the rising edge of vsync so the frog never moves mid-frame.
module frog_position_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRID_SIZE       = 32,
  parameter int H_DISPLAY       = 640,
  parameter int V_DISPLAY       = 480,
  parameter int START_X         = 320,
  parameter int START_Y         = 448
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       vsync,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic       move_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0] GRID    = 10'(GRID_SIZE);
  localparam logic [9:0] X_RIGHT = 10'(H_DISPLAY - 2 * GRID_SIZE);
  localparam logic [9:0] Y_DOWN  = 10'(V_DISPLAY - 2 * GRID_SIZE);

  typedef enum logic [1:0] {IDLE, PENDING, RELEASE} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  // Bit 3 = up, 2 = down, 1 = left, 0 = right.
  logic [3:0] raw;
  logic [3:0] sync_a;
  logic [3:0] sync_b;
  logic [3:0] level;
  logic [3:0] level_prev;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0] press;
  logic       vsync_prev;
  logic       vsync_rise;
  state_t     state;
  dir_t       dir;

  assign raw        = {btn_up, btn_down, btn_left, btn_right};
  assign press      = level & ~level_prev;
  assign vsync_rise = vsync & ~vsync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a     <= '0;
      sync_b     <= '0;
      level      <= '0;
      level_prev <= '0;
      vsync_prev <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync_a     <= raw;
      sync_b     <= sync_a;
      level_prev <= level;
      vsync_prev <= vsync;
      // Any cycle of agreement restarts the count, so bounces never accumulate.
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]   <= '0;
          level[i] <= ~level[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir        <= DIR_UP;
      frog_x     <= 10'(START_X);
      frog_y     <= 10'(START_Y);
      move_pulse <= 1'b0;
    end else begin
      move_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (|press) begin
            state <= PENDING;
            if (press[3])      dir <= DIR_UP;
            else if (press[2]) dir <= DIR_DOWN;
            else if (press[1]) dir <= DIR_LEFT;
            else               dir <= DIR_RIGHT;
          end
        end
        PENDING: begin
          // Blocked steps still consume the press but produce no pulse.
          if (vsync_rise) begin
            state <= RELEASE;
            case (dir)
              DIR_UP: if (frog_y >= GRID) begin
                frog_y     <= frog_y - GRID;
                move_pulse <= 1'b1;
              end
              DIR_DOWN: if (frog_y <= Y_DOWN) begin
                frog_y     <= frog_y + GRID;
                move_pulse <= 1'b1;
              end
              DIR_LEFT: if (frog_x >= GRID) begin
                frog_x     <= frog_x - GRID;
                move_pulse <= 1'b1;
              end
              default: if (frog_x <= X_RIGHT) begin
                frog_x     <= frog_x + GRID;
                move_pulse <= 1'b1;
              end
            endcase
          end
        end
        RELEASE: begin
          if (level == 4'b0000) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_position_ctrl.sv
// Bench for frog_position_ctrl: directed and random button steps against a grid-position model,
// plus a per-cycle monitor on pulse/vsync/position consistency.
module tb_frog_position_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       vsync = 1'b0;
  logic [9:0] frog_x, frog_y;
  logic       move_pulse;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  int exp_x = 320;
  int exp_y = 448;
  int vcnt = 0;

  frog_position_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .vsync(vsync), .frog_x(frog_x), .frog_y(frog_y), .move_pulse(move_pulse)
  );

  always #5 clk = ~clk;

  // vsync: 2-cycle pulse every 100 cycles
  always @(negedge clk) begin
    vcnt = (vcnt + 1) % 100;
    vsync = (vcnt == 50 || vcnt == 51);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Monitor: position changes exactly with the pulse, pulse only on vsync rise, grid-aligned.
  logic [9:0] last_x, last_y;
  logic       prev_vs = 1'b0;
  bit         mon_en = 0;
  always @(posedge clk) begin
    #1;
    if (rst_n && mon_en) begin
      check("pulse_on_change", move_pulse, (frog_x != last_x) || (frog_y != last_y));
      if (move_pulse) check("pulse_at_vsync_rise", {vsync, prev_vs}, 2'b10);
      check("grid_aligned", {frog_x[4:0], frog_y[4:0]}, 0);
      if (move_pulse) pulse_cnt++;
    end
    last_x  = frog_x;
    last_y  = frog_y;
    prev_vs = vsync;
    mon_en  = rst_n;
  end

  task automatic set_btn(input logic [3:0] m);
    btn_up = m[3]; btn_down = m[2]; btn_left = m[1]; btn_right = m[0];
  endtask

  // Reference: priority up>down>left>right, clamped to the visible grid.
  function automatic bit model_step(input logic [3:0] m);
    int nx = exp_x, ny = exp_y;
    if (m[3])      ny = exp_y - 32;
    else if (m[2]) ny = exp_y + 32;
    else if (m[1]) nx = exp_x - 32;
    else if (m[0]) nx = exp_x + 32;
    if (nx < 0 || nx > 640 - 32 || ny < 0 || ny > 480 - 32) return 0;
    exp_x = nx;
    exp_y = ny;
    return 1;
  endfunction

  task automatic press_step(input string tag, input logic [3:0] m, input int hold, input int bounce_n);
    int  p0 = pulse_cnt;
    bit  moved;
    for (int i = 0; i < bounce_n; i++) begin
      set_btn((i % 2 == 0) ? m : 4'b0000);
      repeat (2) @(negedge clk);
    end
    set_btn(m);
    repeat (hold) @(negedge clk);
    set_btn(4'b0000);
    repeat (220) @(negedge clk);
    moved = model_step(m);
    check({tag, "_x"}, frog_x, exp_x);
    check({tag, "_y"}, frog_y, exp_y);
    check({tag, "_pulses"}, pulse_cnt - p0, moved ? 1 : 0);
  endtask

  initial begin
    int p0;
    set_btn(4'b0000);
    repeat (3) @(negedge clk);
    check("reset_x", frog_x, 320);
    check("reset_y", frog_y, 448);
    check("reset_pulse", move_pulse, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_x", frog_x, 320);
    check("post_reset_y", frog_y, 448);

    // Bouncing up button (toggle every 2 cycles for 20 cycles) then held
    press_step("bounce_up", 4'b1000, 40, 10);
    press_step("right_held", 4'b0001, 300, 0);
    press_step("right_again", 4'b0001, 30, 0);
    for (int i = 0; i < 7; i++) press_step("right_run", 4'b0001, 25, 0);
    press_step("right_edge", 4'b0001, 25, 0);
    check("edge_x608", frog_x, 608);
    press_step("down", 4'b0100, 25, 0);
    press_step("down_edge", 4'b0100, 25, 0);
    check("edge_y448", frog_y, 448);
    press_step("up_left", 4'b1010, 25, 0);

    // Reset while a step is pending
    for (int i = 0; i < 200 && !vsync; i++) @(negedge clk);
    check("found_vsync", vsync, 1);
    repeat (5) @(negedge clk);
    set_btn(4'b1000);
    repeat (15) @(negedge clk);
    p0 = pulse_cnt;
    rst_n = 1'b0;
    #1;
    check("pend_rst_x", frog_x, 320);
    check("pend_rst_y", frog_y, 448);
    check("pend_rst_pulse", move_pulse, 0);
    set_btn(4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    exp_x = 320;
    exp_y = 448;
    check("pend_rst_after_x", frog_x, exp_x);
    check("pend_rst_after_y", frog_y, exp_y);
    check("pend_rst_no_pulse", pulse_cnt - p0, 0);

    // Random directions, combos, hold lengths and bounce
    for (int i = 0; i < 30; i++) begin
      press_step("rand", 4'($urandom_range(1, 15)), $urandom_range(10, 150),
                 2 * $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
